// File: rtl/multi_matrix_spi_streamer.sv
// rtl/multi_matrix_spi_streamer.sv - streams one frame to parallel SPI lines while walking a
// one-hot select token through a 74HC595-style chain, one matrix at a time.
module multi_matrix_spi_streamer #(
   parameter int CHANNEL_NUMBER   = 3,
   parameter int WORD_WIDTH       = 8,
   parameter int WORDS_PER_MATRIX = 384,
   parameter int MATRIX_COUNT     = 4,
   parameter int CLK_DIV          = 4,
   parameter int GAP_CYCLES       = 2,
   parameter int MSB_FIRST        = 1
) (
   input  logic                                            clk,
   input  logic                                            rst,
   input  logic                                            start,
   output logic                                            busy,
   output logic                                            done,
   output logic                                            rd_en,
   output logic [$clog2(MATRIX_COUNT*WORDS_PER_MATRIX)-1:0] rd_addr,
   input  logic [CHANNEL_NUMBER*WORD_WIDTH-1:0]            rd_data,
   output logic                                            spi_clk,
   output logic [CHANNEL_NUMBER-1:0]                       spi_mosi,
   output logic                                            ser_clk,
   output logic                                            ser_data,
   output logic                                            ser_stcp,
   output logic                                            ser_n_enable
);

   localparam int ADDR_W  = $clog2(MATRIX_COUNT*WORDS_PER_MATRIX);
   localparam int DATA_W  = CHANNEL_NUMBER*WORD_WIDTH;
   localparam int CNT_MAX = (2*CLK_DIV > GAP_CYCLES) ? 2*CLK_DIV : GAP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int BIT_W   = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
   localparam int W_W     = (WORDS_PER_MATRIX > 1) ? $clog2(WORDS_PER_MATRIX) : 1;
   localparam int M_W     = (MATRIX_COUNT > 1) ? $clog2(MATRIX_COUNT) : 1;

   typedef enum logic [3:0] {
      S_IDLE,
      S_SEL_SHIFT,
      S_SEL_LATCH,
      S_FETCH,
      S_WAIT,
      S_SHIFT,
      S_GAP,
      S_CLR_SHIFT,
      S_CLR_LATCH,
      S_DONE
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [BIT_W-1:0]    bit_idx;
   logic [W_W-1:0]      w_idx;
   logic [M_W-1:0]      m_idx;
   logic [DATA_W-1:0]   shreg;
   logic [DATA_W-1:0]   next_sh;

   logic half_end;
   logic period_end;
   logic shift_last;
   logic word_end;
   logic last_word;
   logic last_matrix;

   function automatic logic [CHANNEL_NUMBER-1:0] first_bits(input logic [DATA_W-1:0] d);
      logic [CHANNEL_NUMBER-1:0] b;
      b = '0;
      for (int c = 0; c < CHANNEL_NUMBER; c++)
         b[c] = (MSB_FIRST != 0) ? d[c*WORD_WIDTH + WORD_WIDTH - 1] : d[c*WORD_WIDTH];
      return b;
   endfunction

   function automatic logic [DATA_W-1:0] shift_words(input logic [DATA_W-1:0] d);
      logic [DATA_W-1:0] r;
      r = '0;
      for (int c = 0; c < CHANNEL_NUMBER; c++) begin
         if (MSB_FIRST != 0)
            r[c*WORD_WIDTH +: WORD_WIDTH] = {d[c*WORD_WIDTH +: WORD_WIDTH-1], 1'b0};
         else
            r[c*WORD_WIDTH +: WORD_WIDTH] = {1'b0, d[c*WORD_WIDTH + 1 +: WORD_WIDTH-1]};
      end
      return r;
   endfunction

   always_comb begin
      next_sh     = shift_words(shreg);
      half_end    = (cnt == CNT_W'(CLK_DIV - 1));
      period_end  = (cnt == CNT_W'(2*CLK_DIV - 1));
      shift_last  = (state == S_SHIFT) && period_end && (bit_idx == BIT_W'(WORD_WIDTH - 1));
      word_end    = ((state == S_GAP) && (cnt == CNT_W'(GAP_CYCLES - 1))) ||
                    (shift_last && (GAP_CYCLES == 0));
      last_word   = (w_idx == W_W'(WORDS_PER_MATRIX - 1));
      last_matrix = (m_idx == M_W'(MATRIX_COUNT - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         cnt          <= '0;
         bit_idx      <= '0;
         w_idx        <= '0;
         m_idx        <= '0;
         shreg        <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         rd_en        <= 1'b0;
         rd_addr      <= '0;
         spi_clk      <= 1'b0;
         spi_mosi     <= '0;
         ser_clk      <= 1'b0;
         ser_data     <= 1'b0;
         ser_stcp     <= 1'b0;
         ser_n_enable <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_SEL_SHIFT;
                  busy     <= 1'b1;
                  m_idx    <= '0;
                  w_idx    <= '0;
                  rd_addr  <= '0;
                  cnt      <= '0;
                  ser_data <= 1'b1;
               end
            end
            // One chain shift: clock low for CLK_DIV, high for CLK_DIV, data held throughout.
            S_SEL_SHIFT, S_CLR_SHIFT: begin
               cnt <= cnt + CNT_W'(1);
               if (half_end)
                  ser_clk <= 1'b1;
               if (period_end) begin
                  ser_clk      <= 1'b0;
                  ser_stcp     <= 1'b1;
                  ser_n_enable <= 1'b0;
                  cnt          <= '0;
                  state        <= (state == S_SEL_SHIFT) ? S_SEL_LATCH : S_CLR_LATCH;
               end
            end
            S_SEL_LATCH, S_CLR_LATCH: begin
               cnt <= cnt + CNT_W'(1);
               if (half_end) begin
                  ser_stcp <= 1'b0;
                  cnt      <= '0;
                  if (state == S_SEL_LATCH) begin
                     rd_en <= 1'b1;
                     state <= S_FETCH;
                  end else begin
                     done         <= 1'b1;
                     ser_n_enable <= 1'b1;
                     state        <= S_DONE;
                  end
               end
            end
            S_FETCH: begin
               rd_en <= 1'b0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               shreg    <= rd_data;
               spi_mosi <= first_bits(rd_data);
               bit_idx  <= '0;
               cnt      <= '0;
               state    <= S_SHIFT;
            end
            S_SHIFT: begin
               cnt <= cnt + CNT_W'(1);
               if (half_end)
                  spi_clk <= 1'b1;
               if (period_end) begin
                  spi_clk <= 1'b0;
                  cnt     <= '0;
                  if (bit_idx == BIT_W'(WORD_WIDTH - 1)) begin
                     spi_mosi <= '0;
                     state    <= S_GAP;
                  end else begin
                     bit_idx  <= bit_idx + BIT_W'(1);
                     shreg    <= next_sh;
                     spi_mosi <= first_bits(next_sh);
                  end
               end
            end
            S_GAP: begin
               cnt <= cnt + CNT_W'(1);
            end
            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

         // Word boundary overrides the per-state next-state; it also covers a zero-length gap.
         if (word_end) begin
            cnt <= '0;
            if (!last_word) begin
               w_idx   <= w_idx + W_W'(1);
               rd_addr <= rd_addr + ADDR_W'(1);
               rd_en   <= 1'b1;
               state   <= S_FETCH;
            end else if (!last_matrix) begin
               w_idx    <= '0;
               m_idx    <= m_idx + M_W'(1);
               rd_addr  <= rd_addr + ADDR_W'(1);
               ser_data <= 1'b0;
               state    <= S_SEL_SHIFT;
            end else begin
               ser_data <= 1'b0;
               state    <= S_CLR_SHIFT;
            end
         end
      end
   end

endmodule

// File: tb/tb_multi_matrix_spi_streamer.sv
// tb/tb_multi_matrix_spi_streamer.sv - self-checking bench, MSB-first and LSB-first instances side by side.
module tb_multi_matrix_spi_streamer;

   localparam int NW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic start;
   logic busy_w[2], done_w[2], rd_en_w[2], spi_clk_w[2];
   logic ser_clk_w[2], ser_data_w[2], ser_stcp_w[2], ser_n_enable_w[2];
   logic [2:0]  rd_addr_w[2];
   logic [2:0]  spi_mosi_w[2];
   logic [23:0] rd_data_w[2];
   logic [23:0] mem[NW];

   int n_checks = 0;
   int n_errors = 0;

   multi_matrix_spi_streamer #(
      .CHANNEL_NUMBER(3), .WORD_WIDTH(8), .WORDS_PER_MATRIX(4), .MATRIX_COUNT(2),
      .CLK_DIV(2), .GAP_CYCLES(3), .MSB_FIRST(1)
   ) u_dut_msb (
      .clk(clk), .rst(rst), .start(start), .busy(busy_w[0]), .done(done_w[0]),
      .rd_en(rd_en_w[0]), .rd_addr(rd_addr_w[0]), .rd_data(rd_data_w[0]),
      .spi_clk(spi_clk_w[0]), .spi_mosi(spi_mosi_w[0]), .ser_clk(ser_clk_w[0]),
      .ser_data(ser_data_w[0]), .ser_stcp(ser_stcp_w[0]), .ser_n_enable(ser_n_enable_w[0])
   );

   multi_matrix_spi_streamer #(
      .CHANNEL_NUMBER(3), .WORD_WIDTH(8), .WORDS_PER_MATRIX(4), .MATRIX_COUNT(2),
      .CLK_DIV(2), .GAP_CYCLES(3), .MSB_FIRST(0)
   ) u_dut_lsb (
      .clk(clk), .rst(rst), .start(start), .busy(busy_w[1]), .done(done_w[1]),
      .rd_en(rd_en_w[1]), .rd_addr(rd_addr_w[1]), .rd_data(rd_data_w[1]),
      .spi_clk(spi_clk_w[1]), .spi_mosi(spi_mosi_w[1]), .ser_clk(ser_clk_w[1]),
      .ser_data(ser_data_w[1]), .ser_stcp(ser_stcp_w[1]), .ser_n_enable(ser_n_enable_w[1])
   );

   // Synchronous buffer: data one cycle after rd_en, garbage otherwise.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++)
         rd_data_w[i] <= rd_en_w[i] ? mem[rd_addr_w[i]] : 24'($urandom);
   end

   int cyc = 0;
   int n_addr[2], n_bits[2], n_ser[2], stcp_cnt[2], done_cnt[2], n_int[2];
   int v_time[2], v_phase[2], v_nen[2], v_chain[2], v_overlap[2], v_done[2];
   int addr_log[2][16];
   logic [2:0] bits_log[2][128];
   logic ser_log[2][8];
   int last_addr[2], last_rd[2], hi_run[2], lo_run[2];
   logic p_spi[2], p_ser[2], p_stcp[2], p_done[2], p_sdata[2];
   logic [1:0] chain_q[2], chain_o[2];

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
         if (rd_en_w[i]) begin
            if (n_addr[i] > 0 && (last_addr[i] / 4) == (int'(rd_addr_w[i]) / 4)) begin
               n_int[i]++;
               if (cyc - last_rd[i] != 37) v_time[i]++;
            end
            if (n_addr[i] < 16) addr_log[i][n_addr[i]] = int'(rd_addr_w[i]);
            n_addr[i]++;
            last_addr[i] = int'(rd_addr_w[i]);
            last_rd[i] = cyc;
         end
         if (spi_clk_w[i] && !p_spi[i]) begin
            if ((n_bits[i] % 8) != 0 && lo_run[i] != 2) v_phase[i]++;
            if (n_bits[i] < 128) bits_log[i][n_bits[i]] = spi_mosi_w[i];
            n_bits[i]++;
            if (ser_n_enable_w[i] !== 1'b0) v_nen[i]++;
            if (chain_o[i] !== ((last_addr[i] < 4) ? 2'b01 : 2'b10)) v_chain[i]++;
         end
         if (!spi_clk_w[i] && p_spi[i] && hi_run[i] != 2) v_phase[i]++;
         if (spi_clk_w[i]) begin hi_run[i]++; lo_run[i] = 0; end
         else begin lo_run[i]++; hi_run[i] = 0; end
         if (spi_clk_w[i] && ser_clk_w[i]) v_overlap[i]++;
         if (ser_clk_w[i] && !p_ser[i]) begin
            if (ser_data_w[i] !== p_sdata[i]) v_chain[i]++;
            if (n_ser[i] == 0 && ser_n_enable_w[i] !== 1'b1) v_nen[i]++;
            if (n_ser[i] < 8) ser_log[i][n_ser[i]] = ser_data_w[i];
            n_ser[i]++;
            chain_q[i] = {chain_q[i][0], ser_data_w[i]};
         end
         if (ser_stcp_w[i] && !p_stcp[i]) begin
            stcp_cnt[i]++;
            chain_o[i] = chain_q[i];
            if (ser_n_enable_w[i] !== 1'b0) v_nen[i]++;
         end
         if (done_w[i]) begin
            done_cnt[i]++;
            if (p_done[i]) v_done[i]++;
         end
         if (!busy_w[i] && !done_w[i] && ser_n_enable_w[i] !== 1'b1) v_nen[i]++;
         p_spi[i]   = spi_clk_w[i];
         p_ser[i]   = ser_clk_w[i];
         p_stcp[i]  = ser_stcp_w[i];
         p_done[i]  = done_w[i];
         p_sdata[i] = ser_data_w[i];
      end
   end

   task automatic clear_mon();
      for (int i = 0; i < 2; i++) begin
         n_addr[i] = 0; n_bits[i] = 0; n_ser[i] = 0; stcp_cnt[i] = 0; done_cnt[i] = 0;
         n_int[i] = 0; v_time[i] = 0; v_phase[i] = 0; v_nen[i] = 0; v_chain[i] = 0;
         v_overlap[i] = 0; v_done[i] = 0; last_addr[i] = 0;
         chain_q[i] = 2'b00; chain_o[i] = 2'b00;
      end
   endtask

   function automatic logic [13:0] outs(input int i);
      return {busy_w[i], done_w[i], rd_en_w[i], rd_addr_w[i], spi_clk_w[i], spi_mosi_w[i],
              ser_clk_w[i], ser_data_w[i], ser_stcp_w[i], ser_n_enable_w[i]};
   endfunction

   function automatic logic [7:0] rev8(input logic [7:0] b);
      logic [7:0] r;
      for (int k = 0; k < 8; k++) r[k] = b[7-k];
      return r;
   endfunction

   // First received bit lands in bit 7.
   function automatic logic [7:0] stream_byte(input int i, input int k, input int c);
      logic [7:0] s;
      for (int b = 0; b < 8; b++) s[7-b] = bits_log[i][k*8+b][c];
      return s;
   endfunction

   task automatic fill_random();
      for (int a = 0; a < NW; a++) mem[a] = 24'($urandom);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while (done_w[0] !== 1'b1 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check("done_within_budget", int'(t < 3000), 1);
   endtask

   task automatic verify_frame(input int i);
      logic [7:0] eb;
      check($sformatf("n_reads[%0d]", i), n_addr[i], 8);
      for (int k = 0; k < 8; k++)
         check($sformatf("rd_addr[%0d] #%0d", i, k), addr_log[i][k], k);
      check($sformatf("spi_edges[%0d]", i), n_bits[i], 64);
      for (int k = 0; k < 8; k++)
         for (int c = 0; c < 3; c++) begin
            eb = mem[k][c*8 +: 8];
            if (i == 1) eb = rev8(eb);
            check($sformatf("stream[%0d] w%0d ch%0d", i, k, c), int'(stream_byte(i, k, c)), int'(eb));
         end
      check($sformatf("ser_edges[%0d]", i), n_ser[i], 3);
      check($sformatf("ser_seq[%0d]", i), int'({ser_log[i][0], ser_log[i][1], ser_log[i][2]}), 3'b100);
      check($sformatf("stcp_pulses[%0d]", i), stcp_cnt[i], 3);
      check($sformatf("done_pulses[%0d]", i), done_cnt[i], 1);
      check($sformatf("chain_final[%0d]", i), int'(chain_o[i]), 0);
      check($sformatf("word_intervals[%0d]", i), n_int[i], 6);
      check($sformatf("word_time_viol[%0d]", i), v_time[i], 0);
      check($sformatf("spi_phase_viol[%0d]", i), v_phase[i], 0);
      check($sformatf("n_enable_viol[%0d]", i), v_nen[i], 0);
      check($sformatf("chain_viol[%0d]", i), v_chain[i], 0);
      check($sformatf("clk_overlap[%0d]", i), v_overlap[i], 0);
      check($sformatf("done_width_viol[%0d]", i), v_done[i], 0);
   endtask

   initial begin
      int seen;
      int t;
      logic [7:0] ab;
      rst = 1'b1;
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         p_spi[i] = 1'b0; p_ser[i] = 1'b0; p_stcp[i] = 1'b0; p_done[i] = 1'b0; p_sdata[i] = 1'b0;
         hi_run[i] = 0; lo_run[i] = 0; last_rd[i] = 0;
      end
      for (int a = 0; a < NW; a++) begin
         ab = 8'(a);
         mem[a] = {8'hC0 | ab, 8'hB0 | ab, 8'hA0 | ab};
      end
      clear_mon();
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) check($sformatf("reset_outs[%0d]", i), int'(outs(i)), 1);
      rst = 1'b0;
      @(negedge clk);

      // Frame 1: reference pattern.
      check("idle_busy", int'(busy_w[0]), 0);
      pulse_start();
      check("busy_after_start", int'(busy_w[0]), 1);
      wait_done();
      repeat (5) @(negedge clk);
      verify_frame(0);
      verify_frame(1);
      check("lsb_word_a1_stream", int'(stream_byte(1, 1, 0)), 8'h85);

      // Frame 2: random data, start while busy and in the done cycle.
      clear_mon();
      fill_random();
      pulse_start();
      repeat ($urandom_range(20, 250)) @(negedge clk);
      pulse_start();
      wait_done();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      check("busy_after_done_start", int'(busy_w[0]), 0);
      verify_frame(0);
      verify_frame(1);

      // Frame 3: reset during SHIFT of word 2.
      clear_mon();
      fill_random();
      pulse_start();
      seen = 0;
      t = 0;
      while (seen < 3 && t < 2000) begin
         @(negedge clk);
         t++;
         if (rd_en_w[0]) seen++;
      end
      check("word2_fetch_seen", seen, 3);
      repeat (2 + $urandom_range(0, 31)) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 2; i++) check($sformatf("abort_outs[%0d]", i), int'(outs(i)), 1);
      rst = 1'b0;
      clear_mon();
      repeat (30) @(negedge clk);
      check("post_abort_reads", n_addr[0], 0);
      check("post_abort_spi", n_bits[0], 0);
      check("post_abort_done", done_cnt[0], 0);

      // Frame 4: clean frame after the abort.
      clear_mon();
      fill_random();
      pulse_start();
      wait_done();
      repeat (5) @(negedge clk);
      verify_frame(0);
      verify_frame(1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/multi_matrix_spi_streamer.md
Name: multi_matrix_spi_streamer

Overview:
- Next-generation output stage of the LED matrix path.
- Reads one frame from the output side of the double buffer and streams it word-by-word to CHANNEL_NUMBER parallel SPI lines.
- Walks a one-hot select token through a 74HC595-style shift-register chain to address MATRIX_COUNT matrices in turn.
- Generalises the single-matrix SPI output stage in channel count, word width, matrix count, bit order, SPI rate and inter-word gap.

Parameters:
- CHANNEL_NUMBER, 3, number of parallel SPI data lines (one per colour bank).
- WORD_WIDTH, 8, bits per SPI word.
- WORDS_PER_MATRIX, 384, words sent per channel per matrix.
- MATRIX_COUNT, 4, matrices in the select chain.
- CLK_DIV, 4, clk cycles per SPI/shift half-period (must be ≥1).
- GAP_CYCLES, 2, idle clk cycles between consecutive SPI words (0 allowed).
- MSB_FIRST, 1, 1 = MSB shifted first, 0 = LSB first.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  single-cycle pulse: transmit one frame.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at end of frame.
- rd_en  out  1  buffer read strobe.
- rd_addr  out  $clog2(MATRIX_COUNT*WORDS_PER_MATRIX)  word address = m*WORDS_PER_MATRIX + w.
- rd_data  in  CHANNEL_NUMBER*WORD_WIDTH  flat; channel c occupies bits [c*WORD_WIDTH +: WORD_WIDTH]. Valid exactly 1 cycle after rd_en.
- spi_clk  out  1  shared SPI clock, mode 0.
- spi_mosi  out  CHANNEL_NUMBER  per-channel data.
- ser_clk, ser_data, ser_stcp  out  1 each  select-chain shift clock, data and latch.
- ser_n_enable  out  1  chain output enable, active-low.

Behaviour:
- One clock (clk); reset synchronous, active-high (rst).
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, spi_clk=0, spi_mosi=0, ser_clk=0, ser_data=0, ser_stcp=0, ser_n_enable=1. All counters 0, state IDLE.
- Reset mid-frame aborts immediately; no partial word or latch completes.
- States:
  - IDLE: ser_n_enable=1. On start, go to SEL_SHIFT with m=0; start is ignored while busy. If rst and start are both high, rst wins.
  - SEL_SHIFT: ser_data = (m==0). ser_clk is low for CLK_DIV cycles, then high for CLK_DIV cycles. Exactly one rising edge, with ser_data stable across it. Then go to SEL_LATCH.
  - SEL_LATCH: ser_stcp high for CLK_DIV cycles, then low. ser_n_enable=0 from here until DONE. Then go to FETCH with w=0.
  - FETCH: rd_en=1 for one cycle with the current rd_addr, then WAIT.
  - WAIT: one cycle; capture rd_data into per-channel shift registers, then SHIFT.
  - SHIFT: WORD_WIDTH bits per word. Each bit:
    - spi_mosi updated while spi_clk=0 and held CLK_DIV cycles;
    - spi_clk high CLK_DIV cycles;
    - spi_clk low again.
    - Bit order set by MSB_FIRST. All channels shift in lockstep.
    - After the last bit: spi_mosi=0, then GAP (GAP_CYCLES cycles, spi_clk=0).
  - After GAP:
    - if w<WORDS_PER_MATRIX-1: w++, go to FETCH;
    - else if m<MATRIX_COUNT-1: m++, go to SEL_SHIFT;
    - else go to CLEAR.
  - CLEAR: one shift with ser_data=0, then a latch, identical timing to SEL. The token leaves the last output and all select outputs end low. Then go to DONE.
  - DONE: done=1 for one cycle, busy=0 next cycle, ser_n_enable=1, return to IDLE. start in the DONE cycle is ignored; start is accepted from IDLE only.
- Per-word time: 2 (FETCH+WAIT) + 2*CLK_DIV*WORD_WIDTH + GAP_CYCLES cycles.
- rd_addr wraps never. The maximum address is MATRIX_COUNT*WORDS_PER_MATRIX-1.
- ser_clk and spi_clk are never high simultaneously.
- All outputs are registered.

Test Plan:
Config for all scenarios: CHANNEL_NUMBER=3, WORD_WIDTH=8, WORDS_PER_MATRIX=4, MATRIX_COUNT=2, CLK_DIV=2, GAP_CYCLES=3, MSB_FIRST=1. Buffer model returns rd_data = {8'hC0|a, 8'hB0|a, 8'hA0|a} for address a.
- Full frame: one start pulse -> rd_addr sequence 0..7, each read exactly once. Slave model captures channel0 A0..A7, channel1 B0..B7, channel2 C0..C7. 64 spi_clk rising edges. done pulses once, 1 cycle wide.
- Select chain: same frame -> ser_clk rises 3 times with ser_data 1,0,0. ser_stcp pulses 3 times. Modelled 2-bit chain outputs: 01 during matrix 0, 10 during matrix 1, 00 after CLEAR. ser_n_enable is 0 only between the first latch and done.
- Word timing: measure from rd_en to next rd_en within a matrix -> exactly 2+32+3=37 cycles. spi_clk high and low phases are each 2 cycles.
- LSB_FIRST (MSB_FIRST=0) with word 8'hA1 -> channel0 bit stream 1,0,0,0,0,1,0,1.
- Start while busy mid-frame -> ignored: address sequence unchanged, one done only.
- rst asserted during SHIFT of word 2 -> next cycle all outputs at reset values. A following start gives a clean full frame beginning at rd_addr=0.
